// File: rtl/mips_pkg.sv
// Shared MIPS decode-stage types and constants.
// Used by reg_scoreboard_file and reg_file_core.
package mips_pkg;

  localparam int unsigned NUM_REGS = 32;

  typedef logic [4:0]  reg_num_t;
  typedef logic [31:0] word_t;

  localparam reg_num_t REG_ZERO = 5'd0;
  localparam reg_num_t REG_RA   = 5'd31;

  // Per-register pending-write counter action for one cycle
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/reg_file_core.sv
// 3-read / 1-write GPR storage with r0 hard-wired to zero.
// Optional feature: define WB_BYPASS_EN to forward the write-back value to
// same-cycle reads of the register being written.
module reg_file_core
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  input  logic [4:0]        rd_addr_c,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  function automatic logic [DATA_W-1:0] read_port(input reg_num_t addr);
    logic [DATA_W-1:0] val;
    val = mem[addr];
    if (addr == REG_ZERO) begin
      val = '0;
    end
`ifdef WB_BYPASS_EN
    else if (wr_en && (wr_addr == addr)) begin
      val = wr_data;
    end
`endif
    return val;
  endfunction

  // Storage: clear on reset, otherwise take the write-back port (r0 writes dropped)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports
  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
    rd_data_c = read_port(rd_addr_c);
  end

endmodule

// File: rtl/reg_scoreboard_file.sv
// GPR file plus per-register in-flight write scoreboard for the decode stage.
// Optional feature: define WB_BYPASS_EN to forward write-back data to reads and
// drop a hazard in the same cycle its last outstanding write retires.
module reg_scoreboard_file
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        reg1_num,
  input  logic [4:0]        reg2_num,
  input  logic [4:0]        saved_num,
  output logic [DATA_W-1:0] reg1_data,
  output logic [DATA_W-1:0] reg2_data,
  output logic [DATA_W-1:0] saved_val_data,
  output logic              has_reg1_hazard,
  output logic              has_reg2_hazard,
  output logic              has_saved_val_hazard,
  input  logic              issue_valid,
  input  logic              issue_reg_write,
  input  logic [4:0]        issue_dest,
  input  logic              wb_en,
  input  logic [4:0]        wb_num,
  input  logic [DATA_W-1:0] wb_data,
  output logic              sb_overflow,
  output logic              sb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef WB_BYPASS_EN
  localparam logic CLEAR_EN = 1'b1;
`else
  localparam logic CLEAR_EN = 1'b0;
`endif

  logic [CNT_W-1:0] cnt    [NUM_REGS];
  cnt_op_e          cnt_op [NUM_REGS];

  logic inc, wb_live, dec, same_reg, ovf_evt, unf_evt;

  reg_file_core #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (reg1_num),
    .rd_addr_b (reg2_num),
    .rd_addr_c (saved_num),
    .rd_data_a (reg1_data),
    .rd_data_b (reg2_data),
    .rd_data_c (saved_val_data),
    .wr_en     (wb_en),
    .wr_addr   (wb_num),
    .wr_data   (wb_data)
  );

  // A register whose only outstanding write retires this cycle is not a
  // hazard when the write-back value is being forwarded.
  function automatic logic hazard_for(input reg_num_t n, input logic [CNT_W-1:0] c,
                                      input logic we, input reg_num_t wn);
    logic clearing;
    clearing = CLEAR_EN && we && (wn == n) && (c == CNT_ONE);
    return (n != REG_ZERO) && (c != '0) && !clearing;
  endfunction

  // Issue/retire events; an increment cancelled by a same-register decrement
  // leaves the counter alone and cannot overflow.
  always_comb begin
    inc      = issue_valid && issue_reg_write && (issue_dest != REG_ZERO);
    wb_live  = wb_en && (wb_num != REG_ZERO);
    dec      = wb_live && (cnt[wb_num] != '0);
    same_reg = inc && dec && (issue_dest == wb_num);
    ovf_evt  = inc && !same_reg && (cnt[issue_dest] == CNT_MAX);
    unf_evt  = wb_live && (cnt[wb_num] == '0);
  end

  // Per-register counter action, saturating at both ends
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_op[i] = CNT_HOLD;
      if (inc && !same_reg && (issue_dest == reg_num_t'(i)) && (cnt[i] != CNT_MAX)) begin
        cnt_op[i] = CNT_INC;
      end else if (dec && !same_reg && (wb_num == reg_num_t'(i))) begin
        cnt_op[i] = CNT_DEC;
      end
    end
  end

  // Scoreboard counters and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt[i] <= '0;
      end
      sb_overflow  <= 1'b0;
      sb_underflow <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        case (cnt_op[i])
          CNT_INC: cnt[i] <= cnt[i] + CNT_ONE;
          CNT_DEC: cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (ovf_evt) sb_overflow  <= 1'b1;
      if (unf_evt) sb_underflow <= 1'b1;
    end
  end

  // Hazard flags for the three decode read ports
  always_comb begin
    has_reg1_hazard      = hazard_for(reg1_num,  cnt[reg1_num],  wb_en, wb_num);
    has_reg2_hazard      = hazard_for(reg2_num,  cnt[reg2_num],  wb_en, wb_num);
    has_saved_val_hazard = hazard_for(saved_num, cnt[saved_num], wb_en, wb_num);
  end

endmodule
